// File: rtl/aes_package.sv
// aes_package: shared types and widths for the streaming AES block engine
package aes_package;
  localparam int ENGINE_CNT_W = 16;
  typedef enum logic [2:0] {IDLE, LOAD_KEY, COLLECT, COMPUTE, EMIT, DONE} aes_engine_state_e;
  typedef struct packed {
    logic start;
    logic clear;
    logic enable;
    logic mode;
    logic [ENGINE_CNT_W-1:0] nb_blocks;
    logic [31:0] ctr_init;
  } ctrl_engine_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic [ENGINE_CNT_W-1:0] blk_cnt;
    aes_engine_state_e state;
  } flags_engine_t;
endpackage

// File: rtl/aes_stream_intf.sv
// aes_stream_intf: valid/ready beat stream between streamer and engine
interface aes_stream_intf #(parameter int DATA_W = 32);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic [DATA_W/8-1:0] strb;
  modport sink (input valid, data, output ready);
  modport source (output valid, data, strb, input ready);
endinterface

// File: rtl/aes_beat_buffer.sv
// aes_beat_buffer: deserialises DATA_W beats into a BLOCK_W register, beat k at bits [k*DATA_W +: DATA_W]
module aes_beat_buffer #(
  parameter int DATA_W = 32,
  parameter int BLOCK_W = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic [DATA_W-1:0] beat,
  output logic [BLOCK_W-1:0] block,
  output logic last
);
  localparam int NB = BLOCK_W / DATA_W;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  logic [IW-1:0] cnt;
  assign last = push && cnt == IW'(NB - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (push) cnt <= last ? '0 : cnt + 1'b1;
    if (push) block <= BLOCK_W'({beat, block} >> DATA_W);
  end
endmodule

// File: rtl/aes_block_engine.sv
// aes_block_engine: streaming AddRoundKey engine (ECB/CTR) with key/data deserialisers and inline serialiser
module aes_block_engine
  import aes_package::*;
#(
  parameter int DATA_W = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W = ENGINE_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic test_mode_i,
  aes_stream_intf.sink a_i,
  aes_stream_intf.sink b_i,
  aes_stream_intf.source d_o,
  input  ctrl_engine_t ctrl_i,
  output flags_engine_t flags_o
);
  localparam int NB_BEATS = BLOCK_W / DATA_W;
  localparam int EW = NB_BEATS > 1 ? $clog2(NB_BEATS) : 1;
  aes_engine_state_e state, state_n;
  logic [BLOCK_W-1:0] key, block, res, result;
  logic key_push, data_push, key_last, data_last, emit_hs, emit_last;
  logic mode, d_valid, busy, done;
  logic [CNT_W-1:0] nb, blk_cnt;
  logic [31:0] ctr;
  logic [EW-1:0] emit_cnt;
  logic [DATA_W-1:0] d_data;
  logic unused_ok;
  assign unused_ok = test_mode_i;
  assign b_i.ready = state == LOAD_KEY && ctrl_i.enable;
  assign a_i.ready = state == COLLECT && ctrl_i.enable;
  assign key_push = b_i.valid && b_i.ready;
  assign data_push = a_i.valid && a_i.ready;
  assign emit_hs = state == EMIT && d_valid && d_o.ready;
  assign emit_last = emit_hs && emit_cnt == EW'(NB_BEATS - 1);
  assign res = block ^ key ^ (mode ? BLOCK_W'(ctr) : '0);
  assign d_o.valid = d_valid;
  assign d_o.data = d_data;
  assign d_o.strb = '1;
  assign flags_o.busy = busy;
  assign flags_o.done = done;
  assign flags_o.blk_cnt = blk_cnt;
  assign flags_o.state = state;
  aes_beat_buffer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_key (
    .clk(clk_i), .rst(rst_i), .clr(ctrl_i.clear), .push(key_push),
    .beat(b_i.data), .block(key), .last(key_last)
  );
  aes_beat_buffer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_data (
    .clk(clk_i), .rst(rst_i), .clr(ctrl_i.clear), .push(data_push),
    .beat(a_i.data), .block(block), .last(data_last)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (ctrl_i.start) state_n = ctrl_i.nb_blocks == '0 ? DONE : LOAD_KEY;
      LOAD_KEY: if (key_last) state_n = COLLECT;
      COLLECT:  if (data_last) state_n = COMPUTE;
      COMPUTE:  state_n = EMIT;
      EMIT:     if (emit_last) state_n = blk_cnt + CNT_W'(1) == nb ? DONE : COLLECT;
      default:  state_n = IDLE;
    endcase
    if (ctrl_i.clear) state_n = IDLE;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_ff @(posedge clk_i) begin
    busy <= !rst_i && state_n != IDLE;
    done <= !rst_i && state_n == DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid <= 1'b0;
      d_data <= '0;
      emit_cnt <= '0;
      blk_cnt <= '0;
    end else if (ctrl_i.clear) begin
      d_valid <= 1'b0;
      emit_cnt <= '0;
      blk_cnt <= '0;
    end else begin
      if (state == IDLE && ctrl_i.start) begin
        mode <= ctrl_i.mode;
        nb <= ctrl_i.nb_blocks;
        ctr <= ctrl_i.ctr_init;
        blk_cnt <= '0;
      end
      if (state == COMPUTE) begin
        d_data <= res[DATA_W-1:0];
        result <= res >> DATA_W;
        d_valid <= 1'b1;
        emit_cnt <= '0;
      end
      if (emit_hs) begin
        d_data <= result[DATA_W-1:0];
        result <= result >> DATA_W;
        emit_cnt <= emit_cnt + 1'b1;
      end
      if (emit_last) begin
        d_valid <= 1'b0;
        emit_cnt <= '0;
        blk_cnt <= blk_cnt + 1'b1;
        ctr <= ctr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_block_engine.sv
// tb_aes_block_engine: directed self-checking bench for the AES block engine
module tb_aes_block_engine;
  import aes_package::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_mode = 1'b0;
  ctrl_engine_t ctrl = '0;
  flags_engine_t flags;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] got[$];
  logic [31:0] key_v[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] dat_v[4] = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
  logic [31:0] ecb_v[4] = '{32'h30201000, 32'h70605040, 32'hB0A09080, 32'hF0E0D0C0};
  aes_stream_intf #(.DATA_W(32)) a_if ();
  aes_stream_intf #(.DATA_W(32)) b_if ();
  aes_stream_intf #(.DATA_W(32)) d_if ();
  aes_block_engine dut (
    .clk_i(clk), .rst_i(rst), .test_mode_i(test_mode),
    .a_i(a_if), .b_i(b_if), .d_o(d_if), .ctrl_i(ctrl), .flags_o(flags)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic mode, input logic [15:0] nb, input logic [31:0] ci);
    ctrl.mode = mode;
    ctrl.nb_blocks = nb;
    ctrl.ctr_init = ci;
    ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
  endtask
  task automatic push(input bit is_key, input logic [31:0] v, input bit stall);
    int cyc = 0;
    logic rdy;
    if (is_key) begin b_if.valid = 1'b1; b_if.data = v; end
    else begin a_if.valid = 1'b1; a_if.data = v; end
    do begin
      if (stall) ctrl.enable = 1'($urandom_range(0, 1));
      #1;
      rdy = is_key ? b_if.ready : a_if.ready;
      tick();
      cyc++;
    end while (!rdy && cyc < 200);
    chk(is_key ? "key_ready" : "data_ready", 64'(rdy), 64'd1);
    b_if.valid = 1'b0;
    a_if.valid = 1'b0;
    ctrl.enable = 1'b1;
  endtask
  task automatic push_key(input bit stall);
    for (int i = 0; i < 4; i++) push(1'b1, key_v[i], stall);
  endtask
  task automatic push_data(input bit stall);
    for (int i = 0; i < 4; i++) push(1'b0, dat_v[i], stall);
  endtask
  task automatic pop_block(input bit stall);
    int n = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic [31:0] held = '0;
    while (n < 4 && cyc < 400) begin
      d_if.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) ctrl.enable = 1'($urandom_range(0, 1));
      if (hold) begin
        chk("hold_valid", 64'(d_if.valid), 64'd1);
        chk("hold_data", 64'(d_if.data), 64'(held));
      end
      hold = d_if.valid && !d_if.ready;
      held = d_if.data;
      if (d_if.valid && d_if.ready) begin
        got.push_back(d_if.data);
        n++;
      end
      tick();
      cyc++;
    end
    chk("pop_beats", 64'(n), 64'd4);
    d_if.ready = 1'b0;
    ctrl.enable = 1'b1;
  endtask
  task automatic check_ecb(input string tag, input int base);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_b%0d", tag, i), 64'(got[base+i]), 64'(ecb_v[i]));
  endtask
  task automatic ecb_job(input string tag);
    got.delete();
    start_job(1'b0, 16'd1, 32'd0);
    push_key(1'b0);
    push_data(1'b0);
    pop_block(1'b0);
    check_ecb(tag, 0);
    chk({tag, "_done"}, 64'(flags.done), 64'd1);
    tick();
  endtask
  task automatic abort_setup();
    start_job(1'b0, 16'd2, 32'd0);
    push_key(1'b0);
    push_data(1'b0);
    pop_block(1'b0);
    push_data(1'b0);
    tick();
    chk("abort_in_emit", 64'(flags.state), 64'(EMIT));
    chk("abort_blk_before", 64'(flags.blk_cnt), 64'd1);
  endtask
  initial begin
    a_if.valid = 1'b0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.data = '0;
    d_if.ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    ctrl.enable = 1'b1;
    chk("rst_valid", 64'(d_if.valid), 64'd0);
    chk("rst_data", 64'(d_if.data), 64'd0);
    chk("rst_a_ready", 64'(a_if.ready), 64'd0);
    chk("rst_b_ready", 64'(b_if.ready), 64'd0);
    chk("rst_busy", 64'(flags.busy), 64'd0);
    chk("rst_done", 64'(flags.done), 64'd0);
    chk("rst_blk_cnt", 64'(flags.blk_cnt), 64'd0);
    chk("rst_state", 64'(flags.state), 64'(IDLE));
    start_job(1'b0, 16'd1, 32'd0);
    chk("ecb_busy", 64'(flags.busy), 64'd1);
    chk("ecb_state_key", 64'(flags.state), 64'(LOAD_KEY));
    chk("ecb_b_ready", 64'(b_if.ready), 64'd1);
    chk("ecb_a_ready", 64'(a_if.ready), 64'd0);
    push_key(1'b0);
    chk("ecb_state_collect", 64'(flags.state), 64'(COLLECT));
    push_data(1'b0);
    chk("ecb_state_compute", 64'(flags.state), 64'(COMPUTE));
    chk("ecb_valid_t1", 64'(d_if.valid), 64'd0);
    tick();
    chk("ecb_valid_t2", 64'(d_if.valid), 64'd1);
    chk("ecb_first_beat", 64'(d_if.data), 64'h30201000);
    chk("ecb_strb", 64'(d_if.strb), 64'hF);
    got.delete();
    pop_block(1'b0);
    check_ecb("ecb", 0);
    chk("ecb_done", 64'(flags.done), 64'd1);
    chk("ecb_blk_cnt", 64'(flags.blk_cnt), 64'd1);
    tick();
    chk("ecb_done_once", 64'(flags.done), 64'd0);
    chk("ecb_idle", 64'(flags.state), 64'(IDLE));
    chk("ecb_not_busy", 64'(flags.busy), 64'd0);
    got.delete();
    start_job(1'b1, 16'd2, 32'd5);
    push_key(1'b0);
    push_data(1'b0);
    pop_block(1'b0);
    chk("ctr_blk_cnt_mid", 64'(flags.blk_cnt), 64'd1);
    chk("ctr_state_mid", 64'(flags.state), 64'(COLLECT));
    push_data(1'b0);
    pop_block(1'b0);
    chk("ctr_done", 64'(flags.done), 64'd1);
    chk("ctr_blk_cnt", 64'(flags.blk_cnt), 64'd2);
    chk("ctr_b0_blk0", 64'(got[0]), 64'h30201005);
    chk("ctr_b0_blk1", 64'(got[4]), 64'h30201006);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("ctr_blk0_b%0d", i), 64'(got[i]), 64'(ecb_v[i]));
      chk($sformatf("ctr_blk1_b%0d", i), 64'(got[4+i]), 64'(ecb_v[i]));
    end
    tick();
    got.delete();
    start_job(1'b1, 16'd2, 32'hFFFFFFFF);
    push_key(1'b0);
    push_data(1'b0);
    pop_block(1'b0);
    push_data(1'b0);
    pop_block(1'b0);
    chk("wrap_b0_blk0", 64'(got[0]), 64'hCFDFEFFF);
    chk("wrap_b0_blk1", 64'(got[4]), 64'h30201000);
    chk("wrap_b3_blk1", 64'(got[7]), 64'hF0E0D0C0);
    tick();
    got.delete();
    start_job(1'b0, 16'd2, 32'd0);
    push_key(1'b1);
    push_data(1'b1);
    pop_block(1'b1);
    push_data(1'b1);
    pop_block(1'b1);
    check_ecb("stall_blk0", 0);
    check_ecb("stall_blk1", 4);
    chk("stall_beats", 64'(got.size()), 64'd8);
    chk("stall_done", 64'(flags.done), 64'd1);
    chk("stall_blk_cnt", 64'(flags.blk_cnt), 64'd2);
    tick();
    start_job(1'b0, 16'd0, 32'd0);
    chk("nb0_done", 64'(flags.done), 64'd1);
    chk("nb0_state", 64'(flags.state), 64'(DONE));
    chk("nb0_a_ready", 64'(a_if.ready), 64'd0);
    chk("nb0_b_ready", 64'(b_if.ready), 64'd0);
    tick();
    chk("nb0_done_once", 64'(flags.done), 64'd0);
    chk("nb0_idle", 64'(flags.state), 64'(IDLE));
    chk("nb0_blk_cnt", 64'(flags.blk_cnt), 64'd0);
    abort_setup();
    ctrl.clear = 1'b1;
    ctrl.start = 1'b1;
    tick();
    ctrl.clear = 1'b0;
    ctrl.start = 1'b0;
    chk("clr_state", 64'(flags.state), 64'(IDLE));
    chk("clr_valid", 64'(d_if.valid), 64'd0);
    chk("clr_blk_cnt", 64'(flags.blk_cnt), 64'd0);
    chk("clr_busy", 64'(flags.busy), 64'd0);
    ecb_job("clr_after");
    abort_setup();
    rst = 1'b1;
    ctrl.start = 1'b1;
    tick();
    rst = 1'b0;
    ctrl.start = 1'b0;
    chk("rst_ab_state", 64'(flags.state), 64'(IDLE));
    chk("rst_ab_valid", 64'(d_if.valid), 64'd0);
    chk("rst_ab_blk_cnt", 64'(flags.blk_cnt), 64'd0);
    chk("rst_ab_data", 64'(d_if.data), 64'd0);
    ecb_job("rst_after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
